// File: rtl/frame_grabber.sv
// Single-frame capture engine: crops a window from a raster pixel stream and box-averages it into OUT_W x OUT_H bytes.
// Optional macro FRAME_GRABBER_THRESH_EN binarises each output pixel against the thresh input.
module frame_grabber #(
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480,
  parameter int PIX_W  = 12,
  parameter int SCALE  = 8,
  parameter int OUT_W  = 28,
  parameter int OUT_H  = 28,
  parameter int X0     = 208,
  parameter int Y0     = 128,
  parameter int ADDR_W = 10,
  parameter int INVERT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [PIX_W-1:0]  in_data,
  input  logic [7:0]        thresh,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int LOG2S = $clog2(SCALE);
  localparam int XW    = $clog2(SRC_W + 1);
  localparam int YW    = $clog2(SRC_H + 1);
  localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int AW    = PIX_W + 2 * LOG2S;

  localparam logic [XW-1:0]     X_LO      = XW'(X0);
  localparam logic [XW-1:0]     X_HI      = XW'(X0 + OUT_W * SCALE);
  localparam logic [XW-1:0]     X_LAST    = XW'(SRC_W - 1);
  localparam logic [XW-1:0]     X_MASK    = XW'(SCALE - 1);
  localparam logic [YW-1:0]     Y_LO      = YW'(Y0);
  localparam logic [YW-1:0]     Y_HI      = YW'(Y0 + OUT_H * SCALE);
  localparam logic [YW-1:0]     Y_MASK    = YW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   busy_nxt, done_nxt;

  logic [XW-1:0]     x_pos, cur_x, dx;
  logic [YW-1:0]     y_pos, cur_y, dy;
  logic [OXW-1:0]    ox;
  logic [OYW-1:0]    oy;
  logic [AW-1:0]     acc [OUT_W];
  logic [AW-1:0]     acc_base, sum;
  logic [7:0]        avg8, pix8, out8;
  logic [ADDR_W-1:0] addr;
  logic              take, in_win, blk_end, wr_last;

  // The sof pixel is always position (0,0), whatever the counters say.
  always_comb begin
    take     = in_valid && (((state == ARMED) && in_sof) || (state == CAPTURE));
    cur_x    = in_sof ? {XW{1'b0}} : x_pos;
    cur_y    = in_sof ? {YW{1'b0}} : y_pos;
    in_win   = (cur_x >= X_LO) && (cur_x < X_HI) && (cur_y >= Y_LO) && (cur_y < Y_HI);
    dx       = cur_x - X_LO;
    dy       = cur_y - Y_LO;
    ox       = OXW'(dx >> LOG2S);
    oy       = OYW'(dy >> LOG2S);
    blk_end  = ((dx & X_MASK) == X_MASK) && ((dy & Y_MASK) == Y_MASK);
    acc_base = in_sof ? {AW{1'b0}} : acc[ox];
    sum      = acc_base + AW'(in_data);
    avg8     = sum[AW-1 -: 8];
    pix8     = (INVERT != 0) ? ~avg8 : avg8;
`ifdef FRAME_GRABBER_THRESH_EN
    out8     = (pix8 >= thresh) ? 8'hFF : 8'h00;
`else
    out8     = pix8;
`endif
    addr     = ADDR_W'(int'(oy) * OUT_W + int'(ox));
    wr_last  = wr_en && (wr_addr == LAST_ADDR);
  end

  // State register plus registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic; arm is only honoured while not busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arm ? ARMED : IDLE;
      ARMED:   state_nxt = (in_valid && in_sof) ? CAPTURE : ARMED;
      CAPTURE: state_nxt = wr_last ? DONE : CAPTURE;
      DONE:    state_nxt = arm ? ARMED : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status decoded from the upcoming state so it registers in step with it.
  always_comb begin
    busy_nxt = (state_nxt == ARMED) || (state_nxt == CAPTURE);
    done_nxt = (state_nxt == DONE);
  end

  // Position tracking, accumulation and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos   <= {XW{1'b0}};
      y_pos   <= {YW{1'b0}};
      wr_en   <= 1'b0;
      wr_addr <= {ADDR_W{1'b0}};
      wr_data <= 8'h00;
      for (int i = 0; i < OUT_W; i++) acc[i] <= {AW{1'b0}};
    end else begin
      wr_en <= 1'b0;
      if (take) begin
        if (cur_x == X_LAST) begin
          x_pos <= {XW{1'b0}};
          y_pos <= cur_y + {{(YW-1){1'b0}}, 1'b1};
        end else begin
          x_pos <= cur_x + {{(XW-1){1'b0}}, 1'b1};
          y_pos <= cur_y;
        end
        if (in_sof) begin
          for (int i = 0; i < OUT_W; i++) acc[i] <= {AW{1'b0}};
        end
        if (in_win) begin
          if (blk_end) begin
            acc[ox] <= {AW{1'b0}};
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= out8;
          end else begin
            acc[ox] <= sum;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_grabber.sv
// Directed bench for frame_grabber on a 16x8 source, 4x2 output, SCALE 2, window at (4,2).
module tb_frame_grabber;

  logic        clk = 1'b0;
  logic        rst, arm, in_valid, in_sof;
  logic [11:0] in_data;
  logic [7:0]  thresh;
  logic        busy0, done0, wr_en0, busy1, done1, wr_en1;
  logic [2:0]  wr_addr0, wr_addr1;
  logic [7:0]  wr_data0, wr_data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc, done_rise_cyc;
  logic done_prev = 1'b0;
  logic [2:0] log_addr0[$];
  logic [7:0] log_data0[$];
  logic [7:0] log_data1[$];

  frame_grabber #(.SRC_W(16), .SRC_H(8), .PIX_W(12), .SCALE(2), .OUT_W(4), .OUT_H(2),
                  .X0(4), .Y0(2), .ADDR_W(3), .INVERT(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .thresh(thresh), .busy(busy0), .done(done0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0));

  frame_grabber #(.SRC_W(16), .SRC_H(8), .PIX_W(12), .SCALE(2), .OUT_W(4), .OUT_H(2),
                  .X0(4), .Y0(2), .ADDR_W(3), .INVERT(1)) dut1 (
    .clk(clk), .rst(rst), .arm(arm), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .thresh(thresh), .busy(busy1), .done(done1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write logger, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en0) begin
      log_addr0.push_back(wr_addr0);
      log_data0.push_back(wr_data0);
      last_wr_cyc = cyc;
    end
    if (wr_en1) log_data1.push_back(wr_data1);
    if (done0 && !done_prev) done_rise_cyc = cyc;
    done_prev = done0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int mode, input int x);
    logic [11:0] xv;
    xv = 12'(x);
    case (mode)
      0:       pix = 12'hFFF;
      1:       pix = xv << 4;
      default: pix = (x < 8) ? 12'h700 : 12'h900;
    endcase
  endfunction

  task automatic send(input int mode, input int n, input int arm_at, input int rst_at);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = pix(mode, i % 16);
      arm      = (i == arm_at);
      rst      = (i == rst_at);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; arm = 1'b0; rst = 1'b0;
  endtask

  task automatic pulse_arm();
    @(posedge clk); #1; arm = 1'b1;
    @(posedge clk); #1; arm = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_log();
    log_addr0.delete(); log_data0.delete(); log_data1.delete();
    last_wr_cyc = -100; done_rise_cyc = -200;
  endtask

  task automatic check_log(input string tag, input logic [7:0] e0 [8], input logic [7:0] e1 [8]);
    check({tag, "_count"}, log_data0.size(), 8);
    check({tag, "_count_inv"}, log_data1.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_data0.size()) begin
        check($sformatf("%s_addr%0d", tag, i), log_addr0[i], i);
        check($sformatf("%s_data%0d", tag, i), log_data0[i], e0[i]);
      end
      if (i < log_data1.size()) check($sformatf("%s_inv%0d", tag, i), log_data1[i], e1[i]);
    end
    check({tag, "_done_lat"}, done_rise_cyc - last_wr_cyc, 1);
    check({tag, "_done"}, done0, 1'b1);
    check({tag, "_busy"}, busy0, 1'b0);
  endtask

  logic [7:0] exp_ff [8], exp_00 [8], exp_ramp [8], exp_ramp_inv [8], exp_th [8], exp_th_inv [8];

  initial begin
    exp_ff       = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_00       = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_ramp     = '{8'h04, 8'h06, 8'h08, 8'h0A, 8'h04, 8'h06, 8'h08, 8'h0A};
    exp_ramp_inv = '{8'hFB, 8'hF9, 8'hF7, 8'hF5, 8'hFB, 8'hF9, 8'hF7, 8'hF5};
`ifdef FRAME_GRABBER_THRESH_EN
    exp_th       = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    exp_th_inv   = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
`else
    exp_th       = '{8'h70, 8'h70, 8'h90, 8'h90, 8'h70, 8'h70, 8'h90, 8'h90};
    exp_th_inv   = '{8'h8F, 8'h8F, 8'h6F, 8'h6F, 8'h8F, 8'h8F, 8'h6F, 8'h6F};
`endif
    rst = 1'b1; arm = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 12'h000; thresh = 8'h80;
    idle(3);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_wr_en", wr_en0, 1'b0);
    check("rst_wr_addr", wr_addr0, 3'd0);
    check("rst_wr_data", wr_data0, 8'h00);
    rst = 1'b0;
    idle(2);

    // Constant white frame.
    clear_log();
    pulse_arm();
    check("arm_busy", busy0, 1'b1);
    send(0, 128, -1, -1);
    idle(4);
    check_log("const", exp_ff, exp_00);

    // Horizontal ramp, pixel = x<<4.
    clear_log();
    pulse_arm();
    check("rearm_done_clr", done0, 1'b0);
    send(1, 128, -1, -1);
    idle(4);
    check_log("ramp", exp_ramp, exp_ramp_inv);

    // Partial white frame with a stray arm, then a restarting ramp frame.
    clear_log();
    pulse_arm();
    send(0, 40, 20, -1);
    check("restart_busy", busy0, 1'b1);
    check("restart_nowr", log_data0.size(), 0);
    send(1, 128, -1, -1);
    idle(4);
    check_log("restart", exp_ramp, exp_ramp_inv);

    // Reset on the cycle a block completes.
    clear_log();
    pulse_arm();
    send(0, 54, -1, 53);
    check("abort_wr_en", wr_en0, 1'b0);
    check("abort_busy", busy0, 1'b0);
    check("abort_done", done0, 1'b0);
    send(0, 128, -1, -1);
    idle(4);
    check("abort_nowr", log_data0.size(), 0);
    check("abort_done_after", done0, 1'b0);

    // Arm alongside a sof in IDLE: that frame is skipped, the next is captured.
    clear_log();
    send(0, 128, 0, -1);
    check("skip_busy", busy0, 1'b1);
    check("skip_nowr", log_data0.size(), 0);
    send(2, 128, -1, -1);
    idle(4);
    check_log("halves", exp_th, exp_th_inv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
